// File: rtl/decode_ctrl_pipe_pkg.sv
// Shared encodings for the pipelined decode helper: extension modes,
// main-control ALU ops, R-type funct values and ALU control codes.
package decode_ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO  = 2'b00,
        EXT_SIGN  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_SIGN2 = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/decode_ctrl_pipe_comb.sv
// Combinational immediate extension, ALU control decode and JR detection
// for one instruction; registered by decode_ctrl_pipe.
module decode_ctrl_comb
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int ALUC_W = 3
) (
    input  logic [IMM_W-1:0]  inst_in,
    input  logic [1:0]        alu_op,
    input  logic [1:0]        ext_mode,
    output logic [DATA_W-1:0] imm_ext,
    output logic [ALUC_W-1:0] alu_control,
    output logic              jr
);

    localparam int PAD_W = DATA_W - IMM_W;

    logic [5:0] funct;
    logic [2:0] code;

    assign funct = inst_in[5:0];

    always_comb begin
        imm_ext = {{PAD_W{inst_in[IMM_W-1]}}, inst_in};
        case (ext_mode_e'(ext_mode))
            EXT_ZERO:  imm_ext = {{PAD_W{1'b0}}, inst_in};
            EXT_UPPER: imm_ext = {inst_in, {PAD_W{1'b0}}};
            default:   ;
        endcase
    end

    always_comb begin
        code = ALUC_ADD;
        jr   = 1'b0;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: code = ALUC_ADD;
            ALUOP_SUB: code = ALUC_SUB;
            ALUOP_OR:  code = ALUC_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: code = ALUC_ADD;
                    FUNCT_SUB: code = ALUC_SUB;
                    FUNCT_AND: code = ALUC_AND;
                    FUNCT_OR:  code = ALUC_OR;
                    FUNCT_SLT: code = ALUC_SLT;
                    FUNCT_JR: begin
                        code = ALUC_ADD;
                        jr   = 1'b1;
                    end
                    default:   code = ALUC_ADD;
                endcase
            end
        endcase
        alu_control = ALUC_W'(code);
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Pipelined decode helper: decode_ctrl_comb followed by NUM_STAGES register
// stages with valid tracking, stall, flush and squash behind a JR redirect.
module decode_ctrl_pipe
    import decode_ctrl_pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int NUM_STAGES = 1,
    parameter int ALUC_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IMM_W-1:0]  inst_in,
    input  logic [1:0]        alu_op,
    input  logic [1:0]        ext_mode,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] imm_out,
    output logic [ALUC_W-1:0] alu_control,
    output logic              jr_sel,
    output logic              out_valid,
    output logic              jr_redirect
);

    logic [DATA_W-1:0] imm_d;
    logic [ALUC_W-1:0] aluc_d;
    logic              jr_d;

    logic [DATA_W-1:0] imm_q   [NUM_STAGES];
    logic [ALUC_W-1:0] aluc_q  [NUM_STAGES];
    logic              jr_q    [NUM_STAGES];
    logic              valid_q [NUM_STAGES];

    decode_ctrl_comb #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W),
        .ALUC_W (ALUC_W)
    ) u_comb (
        .inst_in     (inst_in),
        .alu_op      (alu_op),
        .ext_mode    (ext_mode),
        .imm_ext     (imm_d),
        .alu_control (aluc_d),
        .jr          (jr_d)
    );

    // Everything behind the output stage is younger than the JR, so a
    // redirect clears every valid bit that advances this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                imm_q[k]   <= '0;
                aluc_q[k]  <= '0;
                jr_q[k]    <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                valid_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            imm_q[0]   <= imm_d;
            aluc_q[0]  <= aluc_d;
            jr_q[0]    <= jr_d;
            valid_q[0] <= in_valid & ~jr_redirect;
            for (int k = 1; k < NUM_STAGES; k++) begin
                imm_q[k]   <= imm_q[k-1];
                aluc_q[k]  <= aluc_q[k-1];
                jr_q[k]    <= jr_q[k-1];
                valid_q[k] <= valid_q[k-1] & ~jr_redirect;
            end
        end
    end

    assign imm_out     = imm_q[NUM_STAGES-1];
    assign alu_control = aluc_q[NUM_STAGES-1];
    assign jr_sel      = jr_q[NUM_STAGES-1];
    assign out_valid   = valid_q[NUM_STAGES-1];
    assign jr_redirect = out_valid & jr_sel & ~stall;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: decode table on a 1-stage pipe plus
// reset, stall, flush and JR-squash sequences on 2- and 3-stage pipes.
module tb_decode_ctrl_pipe;

    logic        clk;
    logic        reset;
    logic [15:0] inst;
    logic [1:0]  alu_op;
    logic [1:0]  ext_mode;
    logic        in_valid;
    logic        stall;
    logic        flush;

    logic [31:0] imm1, imm2, imm3;
    logic [2:0]  aluc1, aluc2, aluc3;
    logic        jr1, jr2, jr3;
    logic        vld1, vld2, vld3;
    logic        red1, red2, red3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] inst;
        logic [1:0]  op;
        logic [1:0]  ext;
        logic [31:0] imm;
        logic [2:0]  aluc;
        logic        jr;
    } vec_t;

    vec_t vecs [15];

    decode_ctrl_pipe #(.NUM_STAGES(1)) u1 (
        .clk(clk), .reset(reset), .inst_in(inst), .alu_op(alu_op), .ext_mode(ext_mode),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .imm_out(imm1), .alu_control(aluc1), .jr_sel(jr1), .out_valid(vld1), .jr_redirect(red1)
    );

    decode_ctrl_pipe #(.NUM_STAGES(2)) u2 (
        .clk(clk), .reset(reset), .inst_in(inst), .alu_op(alu_op), .ext_mode(ext_mode),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .imm_out(imm2), .alu_control(aluc2), .jr_sel(jr2), .out_valid(vld2), .jr_redirect(red2)
    );

    decode_ctrl_pipe #(.NUM_STAGES(3)) u3 (
        .clk(clk), .reset(reset), .inst_in(inst), .alu_op(alu_op), .ext_mode(ext_mode),
        .in_valid(in_valid), .stall(stall), .flush(flush),
        .imm_out(imm3), .alu_control(aluc3), .jr_sel(jr3), .out_valid(vld3), .jr_redirect(red3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int d, input logic ev,
                              input logic [31:0] ei, input logic [2:0] ea,
                              input logic ej, input logic er, input logic chk_pl);
        logic [31:0] a_i;
        logic [2:0]  a_a;
        logic        a_j, a_v, a_r;
        case (d)
            1:       begin a_i = imm1; a_a = aluc1; a_j = jr1; a_v = vld1; a_r = red1; end
            2:       begin a_i = imm2; a_a = aluc2; a_j = jr2; a_v = vld2; a_r = red2; end
            default: begin a_i = imm3; a_a = aluc3; a_j = jr3; a_v = vld3; a_r = red3; end
        endcase
        n_checks++;
        if (a_v !== ev) begin
            n_fail++;
            $display("FAIL %s (N=%0d) out_valid got %0b want %0b", tag, d, a_v, ev);
        end
        n_checks++;
        if (a_r !== er) begin
            n_fail++;
            $display("FAIL %s (N=%0d) jr_redirect got %0b want %0b", tag, d, a_r, er);
        end
        if (ev || chk_pl) begin
            n_checks++;
            if (a_i !== ei) begin
                n_fail++;
                $display("FAIL %s (N=%0d) imm_out got %08h want %08h", tag, d, a_i, ei);
            end
            n_checks++;
            if (a_a !== ea) begin
                n_fail++;
                $display("FAIL %s (N=%0d) alu_control got %03b want %03b", tag, d, a_a, ea);
            end
            n_checks++;
            if (a_j !== ej) begin
                n_fail++;
                $display("FAIL %s (N=%0d) jr_sel got %0b want %0b", tag, d, a_j, ej);
            end
        end
    endtask

    task automatic drive(input logic [15:0] i);
        inst     = i;
        alu_op   = 2'b00;
        ext_mode = 2'b00;
        in_valid = 1'b1;
    endtask

    task automatic drive_jr();
        inst     = 16'h0008;
        alu_op   = 2'b10;
        ext_mode = 2'b00;
        in_valid = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        step();
        expect_out(tag, 1, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        expect_out(tag, 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        expect_out(tag, 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h8001, 2'b00, 2'b00, 32'h00008001, 3'b010, 1'b0};
        vecs[1]  = '{16'h8001, 2'b00, 2'b01, 32'hFFFF8001, 3'b010, 1'b0};
        vecs[2]  = '{16'h8001, 2'b00, 2'b10, 32'h80010000, 3'b010, 1'b0};
        vecs[3]  = '{16'h8001, 2'b00, 2'b11, 32'hFFFF8001, 3'b010, 1'b0};
        vecs[4]  = '{16'h0020, 2'b10, 2'b00, 32'h00000020, 3'b010, 1'b0};
        vecs[5]  = '{16'h0022, 2'b10, 2'b00, 32'h00000022, 3'b110, 1'b0};
        vecs[6]  = '{16'h0024, 2'b10, 2'b00, 32'h00000024, 3'b000, 1'b0};
        vecs[7]  = '{16'h0025, 2'b10, 2'b00, 32'h00000025, 3'b001, 1'b0};
        vecs[8]  = '{16'h002A, 2'b10, 2'b00, 32'h0000002A, 3'b111, 1'b0};
        vecs[9]  = '{16'h003F, 2'b10, 2'b00, 32'h0000003F, 3'b010, 1'b0};
        vecs[10] = '{16'h1234, 2'b01, 2'b01, 32'h00001234, 3'b110, 1'b0};
        vecs[11] = '{16'hF000, 2'b11, 2'b01, 32'hFFFFF000, 3'b001, 1'b0};
        vecs[12] = '{16'h7FFF, 2'b11, 2'b10, 32'h7FFF0000, 3'b001, 1'b0};
        vecs[13] = '{16'h0008, 2'b00, 2'b00, 32'h00000008, 3'b010, 1'b0};
        vecs[14] = '{16'h0008, 2'b10, 2'b00, 32'h00000008, 3'b010, 1'b1};

        // Reset held two cycles with in_valid high, then first result latency
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        inst     = 16'h1234;
        alu_op   = 2'b10;
        ext_mode = 2'b01;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            expect_out("reset_hold", 1, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
            expect_out("reset_hold", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
            expect_out("reset_hold", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b0;
        drive(16'h00AB);
        step();
        in_valid = 1'b0;
        expect_out("lat_e1", 1, 1'b1, 32'h000000AB, 3'b010, 1'b0, 1'b0, 1'b0);
        expect_out("lat_e1", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        expect_out("lat_e1", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("lat_e2", 2, 1'b1, 32'h000000AB, 3'b010, 1'b0, 1'b0, 1'b0);
        expect_out("lat_e2", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("lat_e3", 3, 1'b1, 32'h000000AB, 3'b010, 1'b0, 1'b0, 1'b0);

        // Decode table through the single-stage pipe
        do_reset("reset_pre_table");
        for (int i = 0; i < 15; i++) begin
            inst     = vecs[i].inst;
            alu_op   = vecs[i].op;
            ext_mode = vecs[i].ext;
            in_valid = 1'b1;
            step();
            expect_out($sformatf("vec%0d", i), 1, 1'b1, vecs[i].imm, vecs[i].aluc,
                       vecs[i].jr, vecs[i].jr, 1'b0);
        end
        in_valid = 1'b0;

        // Stall with A at the output of the 3-stage pipe; D is dropped
        do_reset("reset_mid_stream");
        drive(16'h000A); step();
        drive(16'h000B); step();
        drive(16'h000C); step();
        expect_out("stall_pre", 3, 1'b1, 32'h0000000A, 3'b010, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        drive(16'h000D);
        step();
        expect_out("stall_c1", 3, 1'b1, 32'h0000000A, 3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("stall_c2", 3, 1'b1, 32'h0000000A, 3'b010, 1'b0, 1'b0, 1'b0);
        stall    = 1'b0;
        in_valid = 1'b0;
        step();
        expect_out("stall_B", 3, 1'b1, 32'h0000000B, 3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("stall_C", 3, 1'b1, 32'h0000000C, 3'b010, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("stall_D_dropped", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Flush with three entries in flight, then flush+stall together
        do_reset("reset_pre_flush");
        drive(16'h0011); step();
        drive(16'h0012); step();
        drive(16'h0013); step();
        expect_out("flush_pre", 3, 1'b1, 32'h00000011, 3'b010, 1'b0, 1'b0, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b0;
        step();
        flush = 1'b0;
        expect_out("flush_c1", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("flush_c2", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("flush_c3", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        drive(16'h0021); step();
        drive(16'h0022); step();
        drive(16'h0023); step();
        expect_out("flush2_pre", 3, 1'b1, 32'h00000021, 3'b010, 1'b0, 1'b0, 1'b0);
        flush    = 1'b1;
        stall    = 1'b1;
        in_valid = 1'b0;
        step();
        flush = 1'b0;
        stall = 1'b0;
        expect_out("flush_stall_c1", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("flush_stall_c2", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("flush_stall_c3", 3, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

        // JR squash on the 2-stage pipe
        do_reset("reset_pre_jr");
        drive_jr();       step();
        drive(16'h0031);  step();
        expect_out("jr_out", 2, 1'b1, 32'h00000008, 3'b010, 1'b1, 1'b1, 1'b0);
        drive(16'h0032);  step();
        in_valid = 1'b0;
        expect_out("jr_squash1", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("jr_squash2", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

        // JR held at the output by stall: no redirect until stall drops
        do_reset("reset_pre_jr_stall");
        drive_jr();       step();
        drive(16'h0041);  step();
        stall = 1'b1;
        drive(16'h0042);
        #1;
        expect_out("jr_stall_c0", 2, 1'b1, 32'h00000008, 3'b010, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("jr_stall_c1", 2, 1'b1, 32'h00000008, 3'b010, 1'b1, 1'b0, 1'b0);
        step();
        expect_out("jr_stall_c2", 2, 1'b1, 32'h00000008, 3'b010, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        #1;
        expect_out("jr_stall_release", 2, 1'b1, 32'h00000008, 3'b010, 1'b1, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        expect_out("jr_stall_squash1", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("jr_stall_squash2", 2, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
